// File: rtl/kpn_pkg.sv
// Shared constants and helpers for the KPN channel FIFO.
// Default word/address widths, read-mode codes, count width helper.
package kpn_pkg;

    localparam int KPN_B     = 16;
    localparam int KPN_W     = 5;
    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Bits needed to hold values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        int n;
        n = 0;
        while ((1 << n) <= depth) n++;
        return n;
    endfunction

endpackage

// File: rtl/kpn_fifo_ram.sv
// Storage array for the KPN channel FIFO.
// Synchronous write port, asynchronous read by address, no reset.
module kpn_fifo_ram #(
    parameter int B = 16,
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         i_we,
    input  logic [W-1:0] i_waddr,
    input  logic [B-1:0] i_wdata,
    input  logic [W-1:0] i_raddr,
    output logic [B-1:0] o_rdata
);

    logic [B-1:0] r_mem [2**W];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/kpn_channel_fifo.sv
// Producer-to-consumer channel FIFO for the KPN fabric.
// Standard or FWFT read, occupancy flags, flush, sticky error flags.
module kpn_channel_fifo
    import kpn_pkg::*;
#(
    parameter int B        = KPN_B,
    parameter int W        = KPN_W,
    parameter int FWFT     = FIFO_STD,
    parameter int AF_LEVEL = 2**W - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            wr,
    input  logic [B-1:0]                    entry_1,
    input  logic                            rd,
    output logic [B-1:0]                    output_1,
    output logic                            empty,
    output logic                            full,
    output logic                            almost_full,
    output logic                            almost_empty,
    output logic [cnt_width(2**W)-1:0]      count,
    output logic                            overflow,
    output logic                            underflow
);

    localparam int            CW      = cnt_width(2**W);
    localparam logic [CW-1:0] C_DEPTH = CW'(2**W);

    logic [W-1:0]  r_wptr;
    logic [W-1:0]  r_rptr;
    logic [CW-1:0] r_count;
    logic          r_empty;
    logic          r_full;
    logic          r_af;
    logic          r_ae;
    logic          r_ovf;
    logic          r_unf;
    logic [B-1:0]  r_out;

    logic          w_rd_ok;
    logic          w_wr_ok;
    logic [CW-1:0] w_cnt_nxt;
    logic [B-1:0]  w_rdata;

    // A full FIFO still takes a write when a read frees a slot this cycle.
    assign w_rd_ok = rd & ~flush & ~r_empty;
    assign w_wr_ok = wr & ~flush & (~r_full | w_rd_ok);

    always_comb begin
        w_cnt_nxt = r_count;
        if (flush)
            w_cnt_nxt = '0;
        else if (w_wr_ok && !w_rd_ok)
            w_cnt_nxt = r_count + CW'(1);
        else if (w_rd_ok && !w_wr_ok)
            w_cnt_nxt = r_count - CW'(1);
    end

    kpn_fifo_ram #(
        .B (B),
        .W (W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (r_wptr),
        .i_wdata (entry_1),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_out   <= '0;
        end else begin
            if (flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_ovf  <= 1'b0;
                r_unf  <= 1'b0;
            end else begin
                if (w_wr_ok) r_wptr <= r_wptr + W'(1);
                if (w_rd_ok) r_rptr <= r_rptr + W'(1);
                if (wr && r_full && !w_rd_ok) r_ovf <= 1'b1;
                if (rd && r_empty) r_unf <= 1'b1;
            end
            r_count <= w_cnt_nxt;
            r_empty <= (w_cnt_nxt == '0);
            r_full  <= (w_cnt_nxt == C_DEPTH);
            r_af    <= (int'(w_cnt_nxt) >= AF_LEVEL);
            r_ae    <= (int'(w_cnt_nxt) <= AE_LEVEL);
            // FWFT keeps a copy of the shown head so output is stable once empty.
            if (FWFT == FIFO_FWFT) begin
                if (!r_empty) r_out <= w_rdata;
            end else if (w_rd_ok) begin
                r_out <= w_rdata;
            end
        end
    end

    assign output_1     = (FWFT == FIFO_FWFT && !r_empty) ? w_rdata : r_out;
    assign empty        = r_empty;
    assign full         = r_full;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

endmodule

// File: tb/tb_kpn_channel_fifo.sv
// Scoreboard bench for kpn_channel_fifo, standard and FWFT instances.
// Queue-based reference model; monitor checks each cycle's expectations.
module tb_kpn_channel_fifo;

    localparam int B     = 16;
    localparam int W     = 5;
    localparam int DEPTH = 32;
    localparam int AF    = 30;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic [B-1:0]  entry_1 = '0;

    logic [B-1:0]  s_out, f_out;
    logic          s_emp, s_ful, s_af, s_ae, s_ovf, s_unf;
    logic          f_emp, f_ful, f_af, f_ae, f_ovf, f_unf;
    logic [W:0]    s_cnt, f_cnt;

    always #5 clk = ~clk;

    kpn_channel_fifo #(.B(B), .W(W), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr(wr),
        .entry_1(entry_1), .rd(rd), .output_1(s_out),
        .empty(s_emp), .full(s_ful), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_cnt),
        .overflow(s_ovf), .underflow(s_unf)
    );

    kpn_channel_fifo #(.B(B), .W(W), .FWFT(1)) u_fw (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr(wr),
        .entry_1(entry_1), .rd(rd), .output_1(f_out),
        .empty(f_emp), .full(f_ful), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_cnt),
        .overflow(f_ovf), .underflow(f_unf)
    );

    typedef struct {
        int cnt;
        bit emp, ful, af, ae, ovf, unf;
        int sout;
        int fout;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] q[$];
    bit          m_ovf, m_unf;
    logic [15:0] m_sout, m_last;
    int          n_pass = 0;
    int          n_tot  = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] want);
        n_tot++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    endfunction

    function automatic void model_reset();
        q.delete();
        m_ovf  = 0;
        m_unf  = 0;
        m_sout = '0;
        m_last = '0;
    endfunction

    task automatic step(bit w, bit r, bit f, logic [15:0] d);
        int   n;
        bit   ar, aw;
        exp_t e;
        @(negedge clk);
        wr = w; rd = r; flush = f; entry_1 = d;
        n  = q.size();
        ar = r && !f && n > 0;
        aw = w && !f && (n < DEPTH || ar);
        if (n > 0) m_last = q[0];
        if (f) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            if (w && n == DEPTH && !ar) m_ovf = 1;
            if (r && n == 0) m_unf = 1;
            if (ar) m_sout = q.pop_front();
            if (aw) q.push_back(d);
        end
        e.cnt  = q.size();
        e.emp  = (q.size() == 0);
        e.ful  = (q.size() == DEPTH);
        e.af   = (q.size() >= AF);
        e.ae   = (q.size() <= AE);
        e.ovf  = m_ovf;
        e.unf  = m_unf;
        e.sout = m_sout;
        e.fout = (q.size() > 0) ? q[0] : m_last;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        wr = 0; rd = 0; flush = 0;
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_count"}, 32'(s_cnt), 0);
        chk({tag, "_empty"}, 32'(s_emp), 1);
        chk({tag, "_full"}, 32'(s_ful), 0);
        chk({tag, "_afull"}, 32'(s_af), 0);
        chk({tag, "_aempty"}, 32'(s_ae), 1);
        chk({tag, "_ovf"}, 32'(s_ovf), 0);
        chk({tag, "_unf"}, 32'(s_unf), 0);
        chk({tag, "_sout"}, 32'(s_out), 0);
        chk({tag, "_fout"}, 32'(f_out), 0);
        chk({tag, "_fcount"}, 32'(f_cnt), 0);
        chk({tag, "_fempty"}, 32'(f_emp), 1);
    endtask

    // Monitor: one expectation per driven cycle, checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count", 32'(s_cnt), e.cnt);
                chk("empty", 32'(s_emp), 32'(e.emp));
                chk("full", 32'(s_ful), 32'(e.ful));
                chk("almost_full", 32'(s_af), 32'(e.af));
                chk("almost_empty", 32'(s_ae), 32'(e.ae));
                chk("overflow", 32'(s_ovf), 32'(e.ovf));
                chk("underflow", 32'(s_unf), 32'(e.unf));
                chk("std_output", 32'(s_out), e.sout);
                chk("fwft_output", 32'(f_out), e.fout);
                chk("fwft_count", 32'(f_cnt), e.cnt);
                chk("fwft_empty", 32'(f_emp), 32'(e.emp));
                chk("fwft_flags", {28'd0, f_ful, f_af, f_ae, f_ovf},
                    {28'd0, e.ful, e.af, e.ae, e.ovf});
                chk("fwft_underflow", 32'(f_unf), 32'(e.unf));
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pw, pr;
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;

        // Fill with 1..32, then an overflowing 33rd write.
        for (int i = 1; i <= 32; i++) step(1, 0, 0, 16'(i));
        step(1, 0, 0, 16'h0021);
        // Drain in order, then an underflowing 33rd read.
        for (int i = 0; i < 32; i++) step(0, 1, 0, 16'h0);
        step(0, 1, 0, 16'h0);
        step(0, 0, 1, 16'h0);

        // Single word through an empty FIFO.
        step(1, 0, 0, 16'h00AB);
        step(0, 0, 0, 16'h0);
        step(0, 1, 0, 16'h0);
        step(0, 0, 0, 16'h0);

        // wr&rd while empty.
        step(0, 0, 1, 16'h0);
        step(1, 1, 0, 16'h0005);
        step(0, 0, 1, 16'h0);

        // Full, then 100 cycles of wr&rd across the pointer wrap.
        for (int i = 0; i < 32; i++) step(1, 0, 0, 16'(16'h0100 + i));
        for (int i = 0; i < 100; i++) step(1, 1, 0, 16'(16'h0200 + i));
        for (int i = 0; i < 22; i++) step(0, 1, 0, 16'h0);
        // Overflow set with 10 words left, then flush with a write pending.
        for (int i = 0; i < 22; i++) step(1, 0, 0, 16'(16'h0300 + i));
        step(1, 0, 0, 16'h0BAD);
        for (int i = 0; i < 22; i++) step(0, 1, 0, 16'h0);
        step(1, 0, 1, 16'h0DED);
        step(0, 1, 0, 16'h0);

        // Randomized phases with shifting write/read bias.
        for (int ph = 0; ph < 6; ph++) begin
            pw = (ph % 2 == 0) ? 75 : 35;
            pr = (ph % 2 == 0) ? 35 : 75;
            if (ph >= 4) begin pw = 60; pr = 60; end
            for (int i = 0; i < 300; i++)
                step($urandom_range(99) < pw, $urandom_range(99) < pr,
                     $urandom_range(99) == 0, 16'($urandom));
        end

        // Asynchronous reset between edges while a write is in flight.
        for (int i = 0; i < 20; i++) step(1, 0, 0, 16'(16'h0400 + i));
        step(0, 1, 0, 16'h0);
        @(negedge clk);
        wr = 1; rd = 1; flush = 0; entry_1 = 16'h0EEE;
        #2 rst_n = 1'b0;
        #1 chk_reset("async_reset");
        model_reset();
        @(negedge clk);
        wr = 0; rd = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++)
            step($urandom_range(99) < 55, $urandom_range(99) < 50, 1'b0,
                 16'($urandom));
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/kpn_channel_fifo.md
# kpn_channel_fifo

Parametrised FIFO channel for the KPN process network, connecting one producer process to one consumer process. It supports configurable word width and depth, and a standard or first-word-fall-through (FWFT) read mode. It provides occupancy count, almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags. It replaces the fixed 16x32 channel FIFO as the standard inter-process link in the KPN fabric.

## Interface
- B, 16, data word width in bits
- W, 5, address bits; depth = 2**W words
- FWFT, 0, 0 = standard read (data one cycle after rd), 1 = head word shown while not empty
- AF_LEVEL, 2**W-2, almost_full asserted when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- flush  in  1  synchronous clear of contents and error flags
- wr  in  1  write request
- entry_1  in  B  write data
- rd  in  1  read request
- output_1  out  B  read data
- empty  out  1  no words stored
- full  out  1  2**W words stored
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  W+1  words stored, 0..2**W
- overflow  out  1  sticky: wr while full and not accepted
- underflow  out  1  sticky: rd while empty

## Operation
- Write is accepted when wr=1, flush=0, and either full=0 or an accepted read occurs in the same cycle. The word is stored at w_ptr, and w_ptr wraps modulo 2**W.
- Read is accepted when rd=1, flush=0 and empty=0; r_ptr wraps modulo 2**W.
- count: +1 on an accepted write only, -1 on an accepted read only, unchanged when both or neither are accepted. full = (count == 2**W); empty = (count == 0). All flags are registered and derived from next count.
- wr&rd while empty: the write is accepted, the read is rejected, underflow is set, and count becomes 1.
- wr&rd while full: both are accepted and count stays 2**W; no overflow.
- Standard mode: output_1 is loaded with mem[r_ptr] on an accepted read and holds otherwise.
- FWFT mode: output_1 = mem[r_ptr] while empty=0. The value is undefined-but-stable (last head) while empty. An accepted rd consumes the displayed word.
- flush: pointers and count go to 0, empty=1, and overflow/underflow are cleared. wr/rd in the same cycle are ignored and do not set error flags. output_1 is held.
- Sticky flags clear only on rst_n=0 or flush.
- Memory contents are not reset.

## Timing
- Reset values: output_1=0, empty=1, full=0, almost_full=0, almost_empty=1, count=0, overflow=0, underflow=0.
- Reset asserted mid-operation: all state returns immediately to the reset values, and the in-flight write is lost.
- Standard mode latency: rd accepted at edge N gives data on output_1 after edge N, valid cycle N+1.
- FWFT mode: a word written into an empty FIFO at edge N appears on output_1 and empty=0 after edge N. The next head appears after the edge that accepts rd.
- Throughput: one write and one read per cycle, sustained at any occupancy.
- Flags update on the same edge as count; no combinational path from wr/rd to flags.

## Structure
- Package kpn_pkg:
  - default B/W constants
  - read-mode constants FIFO_STD=0 and FIFO_FWFT=1
  - count width function clog2-style
- Sub-module kpn_fifo_ram: 2**W x B, synchronous write, asynchronous read by address. Instantiated once.
- Top holds pointers, count, flags, error logic and output register/mux.

## Test plan
- Reset then write 0x0001..0x0020 (32 words, W=5) with no reads → count 32, full=1 at last write, almost_full from count 30. A 33rd write sets overflow=1 and count stays 32.
- Drain a full FIFO in standard mode → output_1 returns 0x0001..0x0020 in order, one cycle after each rd. empty=1 after the 32nd read; a 33rd rd sets underflow=1.
- FWFT=1: write 0x00AB into an empty FIFO → output_1=0x00AB and empty=0 the cycle after the write edge. rd consumes it and empty returns to 1.
- Simultaneous wr/rd:
  - while empty, writing 0x0005 → count 1, underflow=1;
  - while full → count stays 32 and order is preserved across the pointer wrap after 100 continuous wr&rd cycles.
- flush with 10 words stored, overflow=1 and wr=1 in the same cycle → count 0, empty=1, overflow=0, and the write is dropped.
- Assert rst_n low asynchronously mid-burst between clock edges → all outputs take reset values before the next edge. Operation resumes normally after release.
